// File: rtl/friscv_decoder_stage.sv
// friscv instruction decode stage: combinational RV32/64 decode feeding
// a DEPTH-entry bundle FIFO with valid/ready on both sides and flush.
module friscv_decoder_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         aclk,
    input  logic                         srst,
    input  logic                         flush,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic [XLEN-1:0]              inst_pc,
    input  logic [31:0]                  instruction,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [XLEN-1:0]              dec_pc,
    output logic [6:0]                   dec_opcode,
    output logic [2:0]                   dec_funct3,
    output logic [6:0]                   dec_funct7,
    output logic [4:0]                   dec_rs1,
    output logic [4:0]                   dec_rs2,
    output logic [4:0]                   dec_rd,
    output logic [XLEN-1:0]              dec_imm,
    output logic [2:0]                   dec_class,
    output logic [$clog2(DEPTH+1)-1:0]   dec_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        C_PROC, C_LSU, C_AUIPC, C_JAL,
        C_JALR, C_BRANCH, C_SYSTEM, C_ILLEGAL
    } cls_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      cls;
    } ent_t;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic        ill, load_bad;
    cls_e        cls_d;
    ent_t        ent;

    assign op = instruction[6:0];
    assign f3 = instruction[14:12];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25],
                    instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31],
                    instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};

    // LD/LWU only exist on RV64
    assign load_bad = (f3 == 3'b111) ||
                      ((XLEN == 32) && (f3 == 3'b011 || f3 == 3'b110));

    always_comb begin
        cls_d = C_ILLEGAL;
        imm32 = '0;
        ill   = 1'b0;
        case (op)
            OP_LUI:    begin cls_d = C_PROC;   imm32 = imm_u; end
            OP_IMM:    begin cls_d = C_PROC;   imm32 = imm_i; end
            OP_OP:     begin cls_d = C_PROC;   imm32 = '0;    end
            OP_LOAD: begin
                cls_d = C_LSU;
                imm32 = imm_i;
                ill   = load_bad;
            end
            OP_STORE: begin
                cls_d = C_LSU;
                imm32 = imm_s;
                ill   = f3 > 3'b010;
            end
            OP_AUIPC:  begin cls_d = C_AUIPC;  imm32 = imm_u; end
            OP_JAL:    begin cls_d = C_JAL;    imm32 = imm_j; end
            OP_JALR: begin
                cls_d = C_JALR;
                imm32 = imm_i;
                ill   = f3 != 3'b000;
            end
            OP_BRANCH: begin
                cls_d = C_BRANCH;
                imm32 = imm_b;
                ill   = f3[2:1] == 2'b01;
            end
            OP_SYSTEM, OP_FENCE: begin
                cls_d = C_SYSTEM;
                imm32 = imm_i;
            end
            default: ;
        endcase
        if (ill || instruction == 32'h0 || &instruction) begin
            cls_d = C_ILLEGAL;
            imm32 = '0;
        end
    end

    always_comb begin
        ent        = '0;
        ent.pc     = inst_pc;
        ent.opcode = op;
        ent.f3     = f3;
        ent.f7     = instruction[31:25];
        ent.rs1    = instruction[19:15];
        ent.rs2    = instruction[24:20];
        ent.rd     = instruction[11:7];
        ent.imm    = sext(imm32);
        ent.cls    = cls_d;
    end

    ent_t           mem_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           push, pop;

    assign inst_ready = !srst && !flush && (cnt_q < CW'(DEPTH));
    assign dec_valid  = cnt_q != '0;
    assign push       = inst_valid && inst_ready;
    assign pop        = dec_valid && dec_ready && !flush;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push) mem_q[wr_q] <= ent;
        end
    end

    assign dec_pc     = mem_q[rd_q].pc;
    assign dec_opcode = mem_q[rd_q].opcode;
    assign dec_funct3 = mem_q[rd_q].f3;
    assign dec_funct7 = mem_q[rd_q].f7;
    assign dec_rs1    = mem_q[rd_q].rs1;
    assign dec_rs2    = mem_q[rd_q].rs2;
    assign dec_rd     = mem_q[rd_q].rd;
    assign dec_imm    = mem_q[rd_q].imm;
    assign dec_class  = mem_q[rd_q].cls;
    assign dec_count  = cnt_q;

endmodule

// File: tb/tb_friscv_decoder_stage.sv
// Scoreboard bench for friscv_decoder_stage: directed decode vectors,
// backpressure, steady push/pop stream, flush and reset mid-stream.
module tb_friscv_decoder_stage;

    logic        aclk = 1'b0;
    logic        srst = 1'b1;
    logic        flush = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst_pc = '0;
    logic [31:0] instruction = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_imm;
    logic [2:0]  dec_class;
    logic [1:0]  dec_count;

    friscv_decoder_stage #(.XLEN(32), .DEPTH(2)) dut (
        .aclk(aclk), .srst(srst), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .instruction(instruction),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_opcode(dec_opcode),
        .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .dec_class(dec_class),
        .dec_count(dec_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [2:0]  cls;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // monitor: every consumed head must match the oldest expected bundle
    always @(negedge aclk) begin
        if (!srst && !flush && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {32'h0, dec_pc}, 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_pc", {32'h0, dec_pc}, {32'h0, e.pc});
                check("out_class", {61'h0, dec_class}, {61'h0, e.cls});
                check("out_imm", {32'h0, dec_imm}, {32'h0, e.imm});
                check("out_fields",
                      {32'h0, dec_opcode, dec_funct3, dec_funct7,
                       dec_rs1, dec_rs2, dec_rd},
                      {32'h0, e.ins[6:0], e.ins[14:12], e.ins[31:25],
                       e.ins[19:15], e.ins[24:20], e.ins[11:7]});
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [2:0] cls, input logic [31:0] imm);
        int   n;
        bit   done;
        exp_t e;
        n    = 0;
        done = 0;
        inst_valid  = 1'b1;
        inst_pc     = pc;
        instruction = ins;
        while (!done && n < 100) begin
            @(negedge aclk);
            if (inst_ready) begin
                e.pc = pc; e.ins = ins; e.cls = cls; e.imm = imm;
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge aclk);
            #1;
            n++;
        end
        if (!done) check("send_timeout", 64'h0, 64'h1);
        inst_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((dec_count != 0 || exp_q.size() != 0) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("drain_count", {62'h0, dec_count}, 64'h0);
        check("drain_queue", 64'(exp_q.size()), 64'h0);
        @(posedge aclk);
        #1;
    endtask

    // hit the FIFO with flush or srst while it holds two entries
    task automatic kill_test(input bit use_rst);
        dec_ready = 1'b0;
        send(32'h300, 32'h00100093, 3'd0, 32'h1);
        send(32'h304, 32'h00200113, 3'd0, 32'h2);
        check("kill_pre_count", {62'h0, dec_count}, 64'h2);
        inst_valid  = 1'b1;
        inst_pc     = 32'h308;
        instruction = 32'h00300193;
        dec_ready   = 1'b1;
        if (use_rst) srst = 1'b1;
        else flush = 1'b1;
        @(negedge aclk);
        check("kill_ready", {63'h0, inst_ready}, 64'h0);
        @(posedge aclk);
        #1;
        exp_q.delete();
        flush      = 1'b0;
        srst       = 1'b0;
        inst_valid = 1'b0;
        dec_ready  = 1'b0;
        @(negedge aclk);
        check("kill_valid", {63'h0, dec_valid}, 64'h0);
        check("kill_count", {62'h0, dec_count}, 64'h0);
        check("kill_ready_after", {63'h0, inst_ready}, 64'h1);
        if (use_rst) begin
            check("rst_pc_clear", {32'h0, dec_pc}, 64'h0);
            check("rst_imm_clear", {32'h0, dec_imm}, 64'h0);
        end
        @(posedge aclk);
        #1;
        dec_ready = 1'b1;
        send(32'h400, 32'h00500293, 3'd0, 32'h5);
        wait_empty();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_ready", {63'h0, inst_ready}, 64'h0);
        check("rst_valid", {63'h0, dec_valid}, 64'h0);
        check("rst_count", {62'h0, dec_count}, 64'h0);
        check("rst_pc", {32'h0, dec_pc}, 64'h0);
        check("rst_class", {61'h0, dec_class}, 64'h0);
        @(posedge aclk);
        #1;
        srst = 1'b0;

        send(32'h100, 32'hFFF10093, 3'd0, 32'hFFFFFFFF);
        check("lat_valid", {63'h0, dec_valid}, 64'h1);
        check("lat_count", {62'h0, dec_count}, 64'h1);
        check("lat_rd", {59'h0, dec_rd}, 64'h1);
        check("lat_rs1", {59'h0, dec_rs1}, 64'h2);

        send(32'h104, 32'hFE000EE3, 3'd5, 32'hFFFFFFFC);
        send(32'h108, 32'h001000EF, 3'd3, 32'h00000800);
        send(32'h10C, 32'h123452B7, 3'd0, 32'h12345000);
        send(32'h110, 32'h00112423, 3'd1, 32'h00000008);
        send(32'h114, 32'h00000000, 3'd7, 32'h0);
        send(32'h118, 32'hFFFFFFFF, 3'd7, 32'h0);
        send(32'h11C, 32'h00002067, 3'd7, 32'h0);
        send(32'h120, 32'h0000207F, 3'd7, 32'h0);
        send(32'h124, 32'h00003003, 3'd7, 32'h0);
        send(32'h128, 32'h00003463, 3'd7, 32'h0);
        send(32'h12C, 32'h00C000E7, 3'd4, 32'h0000000C);
        send(32'h130, 32'h80000117, 3'd2, 32'h80000000);
        send(32'h134, 32'h30002073, 3'd6, 32'h00000300);
        wait_empty();

        dec_ready = 1'b0;
        send(32'h200, 32'h00A00513, 3'd0, 32'hA);
        send(32'h204, 32'h00B00593, 3'd0, 32'hB);
        fork
            send(32'h208, 32'h00C00613, 3'd0, 32'hC);
        join_none
        repeat (3) begin
            @(negedge aclk);
            check("bp_ready", {63'h0, inst_ready}, 64'h0);
            check("bp_count", {62'h0, dec_count}, 64'h2);
            check("bp_head_pc", {32'h0, dec_pc}, 64'h200);
        end
        @(posedge aclk);
        #1;
        dec_ready = 1'b1;
        wait fork;
        wait_empty();

        for (int i = 0; i < 100; i++) begin
            logic [11:0] imm12;
            logic [4:0]  r1, rd;
            logic [2:0]  fn;
            logic [31:0] ins;
            exp_t        e;
            imm12 = 12'($urandom);
            r1    = 5'($urandom);
            rd    = 5'($urandom);
            fn    = 3'($urandom);
            ins   = {imm12, r1, fn, rd, 7'b0010011};
            inst_valid  = 1'b1;
            inst_pc     = 32'h1000 + 32'(i) * 4;
            instruction = ins;
            @(negedge aclk);
            check("stream_ready", {63'h0, inst_ready}, 64'h1);
            if (inst_ready) begin
                e.pc  = inst_pc;
                e.ins = ins;
                e.cls = 3'd0;
                e.imm = {{20{imm12[11]}}, imm12};
                exp_q.push_back(e);
            end
            if (i > 0)
                check("stream_count", {62'h0, dec_count}, 64'h1);
            @(posedge aclk);
            #1;
        end
        inst_valid = 1'b0;
        wait_empty();

        kill_test(1'b0);
        kill_test(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/friscv_decoder_stage.md
# friscv_decoder_stage

Registered, flow-controlled instruction decode stage for the friscv core, between instruction fetch and the control/processing units. Accepts one 32-bit instruction plus its PC per handshake. Decodes opcode, register indexes, function fields, a fully sign-extended XLEN immediate, an instruction class and legality. Buffers decoded bundles in a DEPTH-entry FIFO with valid/ready on both sides and a pipeline flush.

## Interface
- XLEN, 32: datapath width (32 or 64); width of PC and immediate.
- DEPTH, 2: decoded-bundle FIFO entries (power of two, 2..8).
- aclk  in  1  clock, all logic on rising edge.
- srst  in  1  synchronous reset, active-high.
- flush  in  1  discard all buffered entries and the current input.
- inst_valid  in  1  instruction presented.
- inst_ready  out  1  stage can accept.
- inst_pc  in  XLEN  PC of the instruction.
- instruction  in  32  raw instruction word.
- dec_valid  out  1  decoded bundle available at FIFO head.
- dec_ready  in  1  consumer takes head.
- dec_pc  out  XLEN  PC of head.
- dec_opcode / dec_funct3 / dec_funct7  out  7/3/7  instruction[6:0] / [14:12] / [31:25].
- dec_rs1 / dec_rs2 / dec_rd  out  5/5/5  instruction[19:15] / [24:20] / [11:7].
- dec_imm  out  XLEN  sign-extended immediate per format.
- dec_class  out  3  0 PROC, 1 LSU, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 SYSTEM, 7 ILLEGAL.
- dec_count  out  $clog2(DEPTH+1)  entries held.

## Operation
- Class by opcode:
  - 0110111 LUI, 0010011 OP-IMM and 0110011 OP are PROC.
  - 0000011 LOAD and 0100011 STORE are LSU.
  - 0010111 is AUIPC; 1101111 is JAL; 1100111 is JALR; 1100011 is BRANCH.
  - 1110011 CSR/ECALL/EBREAK and 0001111 FENCE are SYSTEM.
  - Anything else is ILLEGAL.
- Additional ILLEGAL conditions:
  - instruction == 0x00000000 or 0xFFFFFFFF.
  - BRANCH funct3 ∈ {010, 011}.
  - LOAD funct3 ∈ {011, 110, 111} (XLEN=32).
  - STORE funct3 > 010.
  - JALR funct3 ≠ 000.
- Immediate formats (sign bit always instruction[31], extended to XLEN):
  - I (LOAD, OP-IMM, JALR, SYSTEM): [31:20].
  - S: {[31:25], [11:7]}.
  - B: {[31], [7], [30:25], [11:8], 0}.
  - U (LUI/AUIPC): {[31:12], 12'b0}.
  - J: {[31], [19:12], [20], [30:21], 0}.
  - OP and ILLEGAL: 0.
- Decode is combinational on the input. The full bundle {pc, fields, imm, class} is written into the FIFO on inst_valid & inst_ready.
- Head is popped on dec_valid & dec_ready. Order is strictly preserved.
- inst_ready = !srst & !flush & (dec_count < DEPTH). It does not depend on dec_ready, so there is no combinational ready path.
- Simultaneous push and pop: count unchanged, both pointers advance. At full, no push is possible, even if a pop occurs in that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. dec_count increments on push only, decrements on pop only.
- Flush: count and pointers return to 0 next edge. The input presented that cycle is not accepted. A pop in a flush cycle is ignored.
- ILLEGAL entries flow through like any other. Exception handling is downstream.

## Timing
- Reset, evaluated at the edge with srst=1:
  - dec_valid=0, dec_count=0, pointers=0.
  - inst_ready=0 while srst is high, 1 the first cycle after.
  - dec_* data outputs are 0 after reset (storage cleared).
- Latency: instruction accepted at edge N appears with dec_valid=1 after edge N, i.e. one cycle, when the FIFO was empty.
- Throughput: one instruction per cycle with dec_ready held high.
- dec_valid = (dec_count ≠ 0). Head data is stable while dec_valid=1 & dec_ready=0.
- srst or flush mid-stream: all entries are lost in one cycle, and no partial bundle is ever presented.

## Test plan
- Reset release, inst_valid=1, instruction=0xFFF10093 (addi x1,x2,-1), pc=0x100 -> one cycle later dec_valid=1, class=0, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, dec_pc=0x100.
- Format sweep:
  - 0xFE000EE3 (beq x0,x0,-4) -> class 5, imm=0xFFFFFFFC.
  - 0x001000EF (jal x1,+2048) -> class 3, imm=0x00000800.
  - 0x123452B7 (lui x5,0x12345) -> class 0, imm=0x12345000.
  - 0x00112423 (sw x1,8(x2)) -> class 1, imm=8.
- Illegal: 0x00000000, 0xFFFFFFFF, 0x00002067 (jalr funct3=010), 0x0000207F (bad opcode) -> each class 7, still delivered in order.
- Backpressure, DEPTH=2: dec_ready=0, stream 3 instructions -> inst_ready=0 after 2 accepted, dec_count=2, third held. Raise dec_ready -> all 3 exit in input order, one per cycle.
- Concurrent push/pop at count=1 with continuous traffic for 100 random legal words -> dec_count stays 1, output matches a reference model, pointer wrap exercised.
- FIFO holding 2 entries: pulse flush together with inst_valid=1 -> next cycle dec_valid=0, dec_count=0, flushed-cycle input absent from output. Repeat with srst -> same result.
